// File: rtl/mine_placer.sv
// mine_placer: LFSR-driven mine placement that feeds the mine and
// adjacency boards through a shared one-cycle write strobe.
module mine_placer #(
  parameter int width = 8,
  parameter int height = 8,
  parameter int numMines = 10,
  parameter logic [15:0] seed = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic safeEn,
  input  logic [$clog2(width)-1:0] safeX,
  input  logic [$clog2(height)-1:0] safeY,
  output logic [$clog2(width)-1:0] readX,
  output logic [$clog2(height)-1:0] readY,
  input  logic readValue,
  output logic [$clog2(width)-1:0] placeX,
  output logic [$clog2(height)-1:0] placeY,
  output logic placeEn,
  output logic busy,
  output logic done,
  output logic [$clog2(width*height+1)-1:0] minesPlaced
);

  localparam int WX = $clog2(width);
  localparam int WY = $clog2(height);
  localparam int CELLS = width * height;
  localparam int WC = $clog2(CELLS + 1);
  localparam logic [15:0] SEED = (seed == 16'd0) ? 16'hACE1 : seed;
  localparam int LIM0 = (numMines < CELLS) ? numMines : CELLS;
  localparam int LIM1 = (numMines < CELLS - 1) ? numMines : CELLS - 1;
  localparam logic [WC-1:0] T0 = WC'(LIM0);
  localparam logic [WC-1:0] T1 = WC'(LIM1);

  typedef enum logic [2:0] {IDLE, GEN, CHECK, PLACE, DONE} state_t;

  state_t state, nextState;
  logic [15:0] lfsr;
  logic fb;
  logic [WX-1:0] candX, safeXL;
  logic [WY-1:0] candY, safeYL;
  logic safeEnL;
  logic [WC-1:0] target, startTarget;
  logic startOk, inRange, isSafe, accept;

  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign target = safeEnL ? T1 : T0;
  assign startTarget = safeEn ? T1 : T0;
  assign startOk = start && (state == IDLE || state == DONE);
  assign inRange = (int'(candX) < width) && (int'(candY) < height);
  assign isSafe = safeEnL && candX == safeXL && candY == safeYL;
  assign accept = inRange && !readValue && !isSafe;

  assign readX = candX;
  assign readY = candY;
  assign busy = state inside {GEN, CHECK, PLACE};
  assign done = state == DONE;
  assign placeEn = state == PLACE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lfsr <= SEED;
      candX <= '0;
      candY <= '0;
      placeX <= '0;
      placeY <= '0;
      minesPlaced <= '0;
      safeEnL <= 1'b0;
      safeXL <= '0;
      safeYL <= '0;
    end else begin
      state <= nextState;
      lfsr <= {lfsr[14:0], fb};
      if (state == GEN) begin
        candX <= lfsr[WX-1:0];
        candY <= lfsr[WX+WY-1:WX];
      end
      if (startOk) begin
        safeEnL <= safeEn;
        safeXL <= safeX;
        safeYL <= safeY;
        minesPlaced <= '0;
      end
      if (state == CHECK && accept) begin
        placeX <= candX;
        placeY <= candY;
      end
      // saturate so a stray PLACE can never wrap the count
      if (state == PLACE && minesPlaced != target)
        minesPlaced <= minesPlaced + WC'(1);
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE, DONE:
        if (startOk)
          nextState = (startTarget == '0) ? DONE : GEN;
      GEN:   nextState = CHECK;
      CHECK: nextState = accept ? PLACE : GEN;
      PLACE:
        nextState = (minesPlaced + WC'(1) == target) ? DONE : GEN;
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: five parameterisations sharing one clock,
// each backed by a modelled mine board driven from placeEn.
module tb_mine_placer;

  logic clk_tb = 1'b0;
  logic reset_tb = 1'b1;
  always #5 clk_tb = ~clk_tb;

  int passed = 0;
  int total = 0;

  logic start [5];
  logic safeEn [5];
  logic [2:0] safeX [5], safeY [5];
  logic [2:0] rx [5], ry [5], px [5], py [5];
  logic pe [5], busy [5], done [5], rv [5];
  logic [6:0] mp0, mp1, mp2, mp3;
  logic [4:0] mp4;

  logic [63:0] mb [5];
  int pulses [5], dups [5], oob [5];
  int adj0 [64];
  int lfsrBad;
  logic [5:0] log0 [$];
  logic [15:0] m, h1, h2;
  int expQ [$];
  int wLim [5] = '{8, 8, 8, 8, 6};
  int hLim [5] = '{8, 8, 8, 8, 5};

  for (genvar g = 0; g < 5; g++) begin : g_rd
    assign rv[g] = mb[g][{ry[g], rx[g]}];
  end

  mine_placer u0 (.clk(clk_tb), .reset(reset_tb), .start(start[0]),
    .safeEn(safeEn[0]), .safeX(safeX[0]), .safeY(safeY[0]),
    .readX(rx[0]), .readY(ry[0]), .readValue(rv[0]),
    .placeX(px[0]), .placeY(py[0]), .placeEn(pe[0]),
    .busy(busy[0]), .done(done[0]), .minesPlaced(mp0));

  mine_placer #(.numMines(63)) u1 (.clk(clk_tb), .reset(reset_tb),
    .start(start[1]), .safeEn(safeEn[1]), .safeX(safeX[1]),
    .safeY(safeY[1]), .readX(rx[1]), .readY(ry[1]),
    .readValue(rv[1]), .placeX(px[1]), .placeY(py[1]),
    .placeEn(pe[1]), .busy(busy[1]), .done(done[1]),
    .minesPlaced(mp1));

  mine_placer #(.numMines(64)) u2 (.clk(clk_tb), .reset(reset_tb),
    .start(start[2]), .safeEn(safeEn[2]), .safeX(safeX[2]),
    .safeY(safeY[2]), .readX(rx[2]), .readY(ry[2]),
    .readValue(rv[2]), .placeX(px[2]), .placeY(py[2]),
    .placeEn(pe[2]), .busy(busy[2]), .done(done[2]),
    .minesPlaced(mp2));

  mine_placer #(.numMines(0)) u3 (.clk(clk_tb), .reset(reset_tb),
    .start(start[3]), .safeEn(safeEn[3]), .safeX(safeX[3]),
    .safeY(safeY[3]), .readX(rx[3]), .readY(ry[3]),
    .readValue(rv[3]), .placeX(px[3]), .placeY(py[3]),
    .placeEn(pe[3]), .busy(busy[3]), .done(done[3]),
    .minesPlaced(mp3));

  mine_placer #(.width(6), .height(5), .numMines(12)) u4 (
    .clk(clk_tb), .reset(reset_tb), .start(start[4]),
    .safeEn(safeEn[4]), .safeX(safeX[4]), .safeY(safeY[4]),
    .readX(rx[4]), .readY(ry[4]), .readValue(rv[4]),
    .placeX(px[4]), .placeY(py[4]), .placeEn(pe[4]),
    .busy(busy[4]), .done(done[4]), .minesPlaced(mp4));

  // board models plus an independent LFSR reference for u0
  always @(posedge clk_tb or posedge reset_tb) begin
    if (reset_tb) begin
      for (int i = 0; i < 5; i++) begin
        mb[i] <= '0;
        pulses[i] <= 0;
        dups[i] <= 0;
        oob[i] <= 0;
      end
      for (int c = 0; c < 64; c++) adj0[c] <= 0;
      log0.delete();
      lfsrBad <= 0;
      m <= 16'hACE1;
      h1 <= '0;
      h2 <= '0;
    end else begin
      m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      h1 <= m;
      h2 <= h1;
      for (int i = 0; i < 5; i++) begin
        if (pe[i]) begin
          pulses[i] <= pulses[i] + 1;
          if (mb[i][{py[i], px[i]}]) dups[i] <= dups[i] + 1;
          if (int'(px[i]) >= wLim[i] || int'(py[i]) >= hLim[i])
            oob[i] <= oob[i] + 1;
          mb[i][{py[i], px[i]}] <= 1'b1;
        end
      end
      if (pe[0]) begin
        log0.push_back({py[0], px[0]});
        if ({py[0], px[0]} != h2[5:0]) lfsrBad <= lfsrBad + 1;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            nx = int'(px[0]) + dx;
            ny = int'(py[0]) + dy;
            if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 &&
                ny >= 0 && ny < 8)
              adj0[ny*8+nx] <= adj0[ny*8+nx] + 1;
          end
      end
    end
  end

  function automatic int nbr(input logic [63:0] b, input int x,
                             input int y, input int w, input int h);
    int n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < w &&
            y + dy >= 0 && y + dy < h && b[(y+dy)*8 + x+dx])
          n++;
    return n;
  endfunction

  task automatic doReset();
    reset_tb = 1'b1;
    @(negedge clk_tb);
    @(negedge clk_tb);
    reset_tb = 1'b0;
    @(negedge clk_tb);
  endtask

  task automatic pulseStart(input int i);
    @(negedge clk_tb);
    start[i] = 1'b1;
    @(negedge clk_tb);
    start[i] = 1'b0;
  endtask

  task automatic waitDone(input int i, input int limit, output int cyc);
    cyc = 0;
    while (!done[i] && cyc < limit) begin
      @(negedge clk_tb);
      cyc++;
    end
  endtask

  task automatic test_reset();
    doReset();
    total++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || pe[0] !== 1'b0) begin
      $display("FAIL reset_flags: busy=%b done=%b placeEn=%b want 000",
               busy[0], done[0], pe[0]);
    end else passed++;
    total++;
    if (mp0 !== 7'd0 || px[0] !== 3'd0 || py[0] !== 3'd0)
      $display("FAIL reset_regs: mines=%0d px=%0d py=%0d want 0",
               mp0, px[0], py[0]);
    else passed++;
    total++;
    if (rx[0] !== 3'd0 || ry[0] !== 3'd0)
      $display("FAIL reset_cand: rx=%0d ry=%0d want 0", rx[0], ry[0]);
    else passed++;
  endtask

  task automatic test_default();
    int cyc, exp, bad;
    logic [63:0] lb;
    doReset();
    expQ.push_back(10);
    pulseStart(0);
    waitDone(0, 5000, cyc);
    total++;
    if (!done[0]) $display("FAIL default_timeout: done=0 want 1");
    else passed++;
    exp = expQ.pop_front();
    total++;
    if (int'(mp0) !== exp)
      $display("FAIL default_count: got %0d want %0d", mp0, exp);
    else passed++;
    total++;
    if (cyc + 1 < 31)
      $display("FAIL default_latency: got %0d edges want >=31", cyc + 1);
    else passed++;
    total++;
    if (pulses[0] !== 10 || dups[0] !== 0)
      $display("FAIL default_pulses: got %0d dup %0d want 10 dup 0",
               pulses[0], dups[0]);
    else passed++;
    total++;
    if ($countones(mb[0]) !== 10)
      $display("FAIL default_board: got %0d ones want 10",
               $countones(mb[0]));
    else passed++;
    total++;
    if (lfsrBad !== 0)
      $display("FAIL default_lfsr_seq: got %0d off-sequence want 0",
               lfsrBad);
    else passed++;
    lb = '0;
    foreach (log0[k]) lb[log0[k]] = 1'b1;
    bad = 0;
    for (int c = 0; c < 64; c++)
      if (!lb[c] && adj0[c] != nbr(lb, c % 8, c / 8, 8, 8)) bad++;
    total++;
    if (bad !== 0 || lb !== mb[0])
      $display("FAIL default_adjacency: got %0d bad cells want 0", bad);
    else passed++;
  endtask

  task automatic test_safe();
    int cyc, exp;
    logic [63:0] want;
    doReset();
    safeEn[1] = 1'b1;
    safeX[1] = 3'd3;
    safeY[1] = 3'd4;
    expQ.push_back(63);
    pulseStart(1);
    safeX[1] = 3'd0;
    safeY[1] = 3'd0;
    waitDone(1, 30000, cyc);
    exp = expQ.pop_front();
    total++;
    if (!done[1] || int'(mp1) !== exp)
      $display("FAIL safe_count: done=%b got %0d want %0d",
               done[1], mp1, exp);
    else passed++;
    want = ~(64'd1 << 35);
    total++;
    if (mb[1] !== want)
      $display("FAIL safe_board: got %h want %h", mb[1], want);
    else passed++;
    total++;
    if (nbr(mb[1], 3, 4, 8, 8) !== 8 || dups[1] !== 0)
      $display("FAIL safe_adj: got %0d dup %0d want 8 dup 0",
               nbr(mb[1], 3, 4, 8, 8), dups[1]);
    else passed++;
  endtask

  task automatic test_clamp();
    int cyc, exp;
    doReset();
    safeEn[2] = 1'b1;
    safeX[2] = 3'd0;
    safeY[2] = 3'd0;
    expQ.push_back(63);
    pulseStart(2);
    waitDone(2, 30000, cyc);
    exp = expQ.pop_front();
    total++;
    if (!done[2] || int'(mp2) !== exp || pulses[2] !== 63)
      $display("FAIL clamp_64: done=%b got %0d pulses %0d want %0d",
               done[2], mp2, pulses[2], exp);
    else passed++;
    total++;
    if (mb[2][0] !== 1'b0 || $countones(mb[2]) !== 63)
      $display("FAIL clamp_board: got %0d ones want 63",
               $countones(mb[2]));
    else passed++;
    expQ.push_back(0);
    pulseStart(3);
    exp = expQ.pop_front();
    total++;
    if (done[3] !== 1'b1 || busy[3] !== 1'b0)
      $display("FAIL zero_done: done=%b busy=%b want 1 0",
               done[3], busy[3]);
    else passed++;
    repeat (4) @(negedge clk_tb);
    total++;
    if (pulses[3] !== 0 || int'(mp3) !== exp)
      $display("FAIL zero_pulses: got %0d mines %0d want 0",
               pulses[3], mp3);
    else passed++;
  endtask

  task automatic test_odd();
    int cyc, exp;
    doReset();
    expQ.push_back(12);
    pulseStart(4);
    waitDone(4, 10000, cyc);
    exp = expQ.pop_front();
    total++;
    if (!done[4] || int'(mp4) !== exp || pulses[4] !== exp)
      $display("FAIL odd_count: got %0d pulses %0d want %0d",
               mp4, pulses[4], exp);
    else passed++;
    total++;
    if (oob[4] !== 0 || dups[4] !== 0 || $countones(mb[4]) !== 12)
      $display("FAIL odd_range: oob %0d dup %0d ones %0d want 0 0 12",
               oob[4], dups[4], $countones(mb[4]));
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc, exp;
    doReset();
    pulseStart(0);
    cyc = 0;
    while (pulses[0] < 4 && cyc < 2000) begin
      @(negedge clk_tb);
      cyc++;
    end
    reset_tb = 1'b1;
    #1;
    total++;
    if (busy[0] !== 1'b0 || pe[0] !== 1'b0 || mp0 !== 7'd0 ||
        mb[0] !== 64'd0 || cyc >= 2000)
      $display("FAIL midreset: busy=%b pe=%b mines=%0d board=%h want 0",
               busy[0], pe[0], mp0, mb[0]);
    else passed++;
    @(negedge clk_tb);
    reset_tb = 1'b0;
    @(negedge clk_tb);
    expQ.push_back(10);
    pulseStart(0);
    repeat (5) @(negedge clk_tb);
    pulseStart(0);
    waitDone(0, 5000, cyc);
    exp = expQ.pop_front();
    total++;
    if (!done[0] || int'(mp0) !== exp || pulses[0] !== exp)
      $display("FAIL busy_start: got %0d pulses %0d want %0d",
               mp0, pulses[0], exp);
    else passed++;
    expQ.push_back(10);
    pulseStart(0);
    total++;
    if (busy[0] !== 1'b1 || mp0 !== 7'd0)
      $display("FAIL restart: busy=%b mines=%0d want 1 0", busy[0], mp0);
    else passed++;
    waitDone(0, 5000, cyc);
    exp = expQ.pop_front();
    total++;
    if (!done[0] || int'(mp0) !== exp || pulses[0] !== 20 ||
        dups[0] !== 0 || $countones(mb[0]) !== 20)
      $display("FAIL restart_count: got %0d pulses %0d dup %0d want %0d",
               mp0, pulses[0], dups[0], exp);
    else passed++;
    total++;
    if (lfsrBad !== 0)
      $display("FAIL restart_lfsr_seq: got %0d want 0", lfsrBad);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      start[i] = 1'b0;
      safeEn[i] = 1'b0;
      safeX[i] = 3'd0;
      safeY[i] = 3'd0;
    end
    test_reset();
    test_default();
    test_safe();
    test_clamp();
    test_odd();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
